// File: rtl/fp_special_classify_pipe.sv
// rtl/fp_special_classify_pipe.sv - two-stage handshaked IEEE special-value classifier for add/sub/mul
`ifndef FP_SPECIAL_CLASSIFY_DEFS
`define FP_SPECIAL_CLASSIFY_DEFS
`define FP32 0
`define FP64 1
`define GET_FP_LEN(f) (((f) == `FP64) ? 64 : 32)
`define GET_EXP_LEN(f) (((f) == `FP64) ? 11 : 8)
`define GET_MANTISSA_LEN(f) (((f) == `FP64) ? 52 : 23)
`define NORMAL 2'b00
`define ZERO 2'b01
`define INF 2'b10
`define NAN 2'b11
`endif

module fp_special_classify_pipe #(
  parameter int data_format = `FP32,
  parameter int CNT_W = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        in_op,
  input  logic [`GET_FP_LEN(data_format)-1:0] in_a,
  input  logic [`GET_FP_LEN(data_format)-1:0] in_b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [1:0]                        out_special,
  output logic [`GET_FP_LEN(data_format)-1:0] out_result,
  output logic                              out_invalid,
  output logic [1:0]                        out_op,
  output logic [`GET_FP_LEN(data_format)-1:0] out_a,
  output logic [`GET_FP_LEN(data_format)-1:0] out_b,
  input  logic                              cnt_clr,
  output logic [CNT_W-1:0]                  nan_cnt
);

  localparam int W  = `GET_FP_LEN(data_format);
  localparam int EW = `GET_EXP_LEN(data_format);
  localparam int MW = `GET_MANTISSA_LEN(data_format);
  localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic s1_valid;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  logic a_ones, a_man_nz, a_exp_z, b_ones, b_man_nz, b_exp_z;
  assign a_ones   = &in_a[W-2 -: EW];
  assign a_exp_z  = ~|in_a[W-2 -: EW];
  assign a_man_nz = |in_a[MW-1:0];
  assign b_ones   = &in_b[W-2 -: EW];
  assign b_exp_z  = ~|in_b[W-2 -: EW];
  assign b_man_nz = |in_b[MW-1:0];

  logic [1:0]   s1_op;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  logic         s1_a_nan, s1_a_snan, s1_a_inf, s1_a_zero;
  logic         s1_b_nan, s1_b_snan, s1_b_inf, s1_b_zero;

  // s1_b carries the effective sign, which equals the raw sign for mul
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= 2'b00;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_a_nan  <= 1'b0;
      s1_a_snan <= 1'b0;
      s1_a_inf  <= 1'b0;
      s1_a_zero <= 1'b0;
      s1_b_nan  <= 1'b0;
      s1_b_snan <= 1'b0;
      s1_b_inf  <= 1'b0;
      s1_b_zero <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op     <= in_op;
        s1_a      <= in_a;
        s1_b      <= {in_b[W-1] ^ (in_op == 2'b01), in_b[W-2:0]};
        s1_a_nan  <= a_ones & a_man_nz;
        s1_a_snan <= a_ones & a_man_nz & ~in_a[MW-1];
        s1_a_inf  <= a_ones & ~a_man_nz;
        s1_a_zero <= a_exp_z & ~a_man_nz;
        s1_b_nan  <= b_ones & b_man_nz;
        s1_b_snan <= b_ones & b_man_nz & ~in_b[MW-1];
        s1_b_inf  <= b_ones & ~b_man_nz;
        s1_b_zero <= b_exp_z & ~b_man_nz;
      end
    end
  end

  logic         sa, sb;
  logic [1:0]   special_d;
  logic         sign_d;
  logic         invalid_d;
  logic [W-1:0] result_d;

  assign sa = s1_a[W-1];
  assign sb = s1_b[W-1];

  always_comb begin
    special_d = `NORMAL;
    sign_d    = 1'b0;
    invalid_d = s1_a_snan | s1_b_snan;
    result_d  = '0;
    if (s1_a_nan | s1_b_nan) begin
      special_d = `NAN;
    end else if (s1_op == 2'b10) begin
      if ((s1_a_inf & s1_b_zero) | (s1_a_zero & s1_b_inf)) begin
        special_d = `NAN;
        invalid_d = 1'b1;
      end else if (s1_a_inf | s1_b_inf) begin
        special_d = `INF;
        sign_d    = sa ^ sb;
      end else if (s1_a_zero | s1_b_zero) begin
        special_d = `ZERO;
        sign_d    = sa ^ sb;
      end
    end else begin
      if (s1_a_inf & s1_b_inf & (sa != sb)) begin
        special_d = `NAN;
        invalid_d = 1'b1;
      end else if (s1_a_inf) begin
        special_d = `INF;
        sign_d    = sa;
      end else if (s1_b_inf) begin
        special_d = `INF;
        sign_d    = sb;
      end else if (s1_a_zero & s1_b_zero) begin
        special_d = `ZERO;
        sign_d    = sa & sb;
      end
    end
    case (special_d)
      `NAN:    result_d = QNAN;
      `INF:    result_d = {sign_d, {EW{1'b1}}, {MW{1'b0}}};
      `ZERO:   result_d = {sign_d, {(W-1){1'b0}}};
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_special <= `NORMAL;
      out_result  <= '0;
      out_invalid <= 1'b0;
      out_op      <= 2'b00;
      out_a       <= '0;
      out_b       <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_special <= special_d;
        out_result  <= result_d;
        out_invalid <= invalid_d;
        out_op      <= s1_op;
        out_a       <= s1_a;
        out_b       <= s1_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan_cnt <= '0;
    end else if (cnt_clr) begin
      nan_cnt <= '0;
    end else if (out_valid && out_ready && (out_special == `NAN) && (nan_cnt != CNT_MAX)) begin
      nan_cnt <= nan_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_special_classify_pipe.sv
// tb/tb_fp_special_classify_pipe.sv - self-checking bench for fp_special_classify_pipe
module tb_fp_special_classify_pipe;

  localparam logic [1:0] C_NORMAL = 2'b00;
  localparam logic [1:0] C_ZERO   = 2'b01;
  localparam logic [1:0] C_INF    = 2'b10;
  localparam logic [1:0] C_NAN    = 2'b11;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, out_invalid, cnt_clr;
  logic [1:0] in_op, out_special, out_op;
  logic [31:0] in_a, in_b, out_result, out_a, out_b;
  logic [CW-1:0] nan_cnt;

  always #5 clk = ~clk;

  fp_special_classify_pipe #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_special(out_special),
    .out_result(out_result), .out_invalid(out_invalid), .out_op(out_op),
    .out_a(out_a), .out_b(out_b), .cnt_clr(cnt_clr), .nan_cnt(nan_cnt)
  );

  typedef struct packed {
    logic [1:0]  sp;
    logic [31:0] res;
    logic        inv;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cnt_model = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int ea, eb, ma, mb;
    bit sa, sb, na, nb, ia, ib, za, zb, s;
    ea = int'(a[30:23]); ma = int'(a[22:0]);
    eb = int'(b[30:23]); mb = int'(b[22:0]);
    sa = a[31];
    sb = b[31] ^ (op == 2'd1);
    na = (ea == 255) && (ma != 0);
    nb = (eb == 255) && (mb != 0);
    ia = (ea == 255) && (ma == 0);
    ib = (eb == 255) && (mb == 0);
    za = (ea == 0) && (ma == 0);
    zb = (eb == 0) && (mb == 0);
    e.inv = (na && a[22] == 1'b0) || (nb && b[22] == 1'b0);
    s = 1'b0;
    e.sp = C_NORMAL;
    if (na || nb) e.sp = C_NAN;
    else if (op == 2'd2) begin
      if ((ia && zb) || (za && ib)) begin e.sp = C_NAN; e.inv = 1'b1; end
      else if (ia || ib) begin e.sp = C_INF; s = sa ^ sb; end
      else if (za || zb) begin e.sp = C_ZERO; s = sa ^ sb; end
    end else begin
      if (ia && ib && (sa != sb)) begin e.sp = C_NAN; e.inv = 1'b1; end
      else if (ia) begin e.sp = C_INF; s = sa; end
      else if (ib) begin e.sp = C_INF; s = sb; end
      else if (za && zb) begin e.sp = C_ZERO; s = sa && sb; end
    end
    case (e.sp)
      C_NAN:   e.res = 32'h7FC00000;
      C_INF:   e.res = s ? 32'hFF800000 : 32'h7F800000;
      C_ZERO:  e.res = s ? 32'h80000000 : 32'h00000000;
      default: e.res = 32'h0;
    endcase
    e.op = op;
    e.a  = a;
    e.b  = {sb, b[30:0]};
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 10)
      0: return 32'h00000000;
      1: return 32'h80000000;
      2: return 32'h7F800000;
      3: return 32'hFF800000;
      4: return 32'h7FC00000;
      5: return 32'h7F800001;
      6: return 32'hFFC00005;
      7: return 32'h3F800000;
      default: return $urandom;
    endcase
  endfunction

  task automatic cyc(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic ordy, input logic clr, output logic fired);
    logic fo;
    exp_t e;
    in_valid = v; in_op = op; in_a = a; in_b = b; out_ready = ordy; cnt_clr = clr;
    @(negedge clk);
    fired = in_valid && in_ready;
    fo = out_valid && out_ready;
    chk("nan_cnt", 32'(nan_cnt), 32'(cnt_model));
    if (out_valid) begin
      chk("out_has_model", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q[0];
        chk("special", 32'(out_special), 32'(e.sp));
        chk("result", out_result, e.res);
        chk("invalid", 32'(out_invalid), 32'(e.inv));
        chk("op", 32'(out_op), 32'(e.op));
        chk("a", out_a, e.a);
        chk("b", out_b, e.b);
      end
    end
    if (clr) cnt_model = 0;
    else if (fo && q.size() > 0 && q[0].sp == C_NAN && cnt_model < (1 << CW) - 1) cnt_model++;
    if (fo && q.size() > 0) void'(q.pop_front());
    if (fired) q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic f;
    for (int k = 0; k < n; k++) cyc(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, f);
  endtask

  initial begin
    logic f;
    logic pv;
    logic [1:0] pop;
    logic [31:0] pa, pb;
    logic ordy;

    rst = 1'b1;
    in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_special", 32'(out_special), 32'(C_NORMAL));
    chk("rst_result", out_result, 32'h0);
    chk("rst_nan_cnt", 32'(nan_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    cyc(1'b1, 2'd0, 32'h3F800000, 32'h40000000, 1'b1, 1'b0, f);
    chk("t1_accept", 32'(f), 32'd1);
    chk("t1_lat_c1", 32'(out_valid), 32'd0);
    idle(1);
    chk("t1_lat_c2", 32'(out_valid), 32'd1);
    idle(2);

    cyc(1'b1, 2'd1, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0, f);
    idle(3);
    chk("t2_cnt", 32'(nan_cnt), 32'd1);

    cyc(1'b1, 2'd2, 32'hFF800000, 32'h00000000, 1'b1, 1'b0, f);
    cyc(1'b1, 2'd2, 32'hFF800000, 32'h3F800000, 1'b1, 1'b0, f);
    idle(3);
    chk("t3_cnt", 32'(nan_cnt), 32'd2);

    cyc(1'b1, 2'd0, 32'h80000000, 32'h80000000, 1'b1, 1'b0, f);
    cyc(1'b1, 2'd0, 32'h80000000, 32'h00000000, 1'b1, 1'b0, f);
    cyc(1'b1, 2'd3, 32'hFF800000, 32'h7F800000, 1'b1, 1'b0, f);
    idle(3);

    cyc(1'b1, 2'd0, 32'h7F800001, 32'h3F800000, 1'b1, 1'b0, f);
    cyc(1'b1, 2'd0, 32'h7FC00001, 32'h3F800000, 1'b1, 1'b0, f);
    idle(3);
    chk("t5_cnt_sat", 32'(nan_cnt), 32'd3);

    cyc(1'b1, 2'd0, 32'h7FC00000, 32'h0, 1'b1, 1'b0, f);
    idle(1);
    chk("clr_coincide_valid", 32'(out_valid), 32'd1);
    cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, f);
    idle(1);
    chk("clr_wins", 32'(nan_cnt), 32'd0);

    pv = 1'b1; pop = 2'($urandom % 4); pa = pick(); pb = pick();
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        rst = 1'b1;
        #2;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_nan_cnt", 32'(nan_cnt), 32'd0);
        q.delete();
        cnt_model = 0;
        @(posedge clk); #1;
        rst = 1'b0;
      end
      if (i < 150) ordy = ((i % 4) == 1 || (i % 4) == 2) ? 1'b0 : 1'b1;
      else ordy = 1'($urandom % 2);
      cyc(pv, pop, pa, pb, ordy, 1'(($urandom % 40) == 0), f);
      if (f || !pv) begin
        pv = 1'(($urandom % 4) != 0);
        pop = 2'($urandom % 4);
        pa = pick();
        pb = pick();
      end
    end
    idle(6);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
